// File: rtl/serial_shift_arbiter.sv
// ---------------------------------------------------------------------------
// serial_shift_arbiter
//
// Shares one serial shift engine between the 7-segment chain and the LED
// chain. Each requester presents a parallel pattern and holds a level req;
// the engine grants round-robin, pulses the granted ack while capturing the
// pattern, shifts it out on the granted chain's clk/sout pins, then pulses
// that chain's latch enable (pen). The non-granted chain's clk/sout/pen
// stay at 0.
//
// Parameters
//   SEG_W  7-segment chain length in bits
//   LED_W  LED chain length in bits
//   DIV    shift-clock half-period in clk cycles (>= 1)
//
// Ports
//   clk, rstn                 system clock, asynchronous active-low reset
//   seg_req/seg_data/seg_ack  7-segment requester handshake and pattern
//   led_req/led_data/led_ack  LED requester handshake and pattern
//   busy                      high while a transfer is in LOAD/SHIFT/LATCH
//   seg_clk/seg_sout/seg_pen/seg_clrn  7-segment chain pins
//   led_clk/led_sout/led_pen/led_clrn  LED chain pins
//
// Build option
//   SERIAL_LSB_FIRST_EN  when defined, patterns are shifted LSB-first
//                        (LSB-aligned register shifting right); otherwise
//                        MSB-first. Timing and handshake are identical.
//
// All outputs are registered: the output decode works on next-cycle state,
// so each pin register holds the value belonging to the current state.
// ---------------------------------------------------------------------------
module serial_shift_arbiter #(
    parameter int unsigned SEG_W = 64,
    parameter int unsigned LED_W = 16,
    parameter int unsigned DIV   = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             seg_req,
    input  logic [SEG_W-1:0] seg_data,
    output logic             seg_ack,
    input  logic             led_req,
    input  logic [LED_W-1:0] led_data,
    output logic             led_ack,
    output logic             busy,
    output logic             seg_clk,
    output logic             seg_sout,
    output logic             seg_pen,
    output logic             seg_clrn,
    output logic             led_clk,
    output logic             led_sout,
    output logic             led_pen,
    output logic             led_clrn
);

    localparam int unsigned MAX_W = (SEG_W > LED_W) ? SEG_W : LED_W;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam int unsigned PH_N  = 2 * DIV;
    localparam int unsigned PH_W  = $clog2(PH_N);

    localparam logic G_SEG = 1'b0;
    localparam logic G_LED = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    // Control / datapath registers
    state_t             r_state;
    logic               r_grant;
    logic               r_last;
    logic [MAX_W-1:0]   r_sreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [PH_W-1:0]    r_ph_cnt;

    // Output registers
    logic               r_seg_ack;
    logic               r_led_ack;
    logic               r_busy;
    logic               r_seg_clk;
    logic               r_seg_sout;
    logic               r_seg_pen;
    logic               r_seg_clrn;
    logic               r_led_clk;
    logic               r_led_sout;
    logic               r_led_pen;
    logic               r_led_clrn;

    // Next-cycle values
    state_t             w_state_nxt;
    logic               w_grant_nxt;
    logic               w_last_nxt;
    logic [MAX_W-1:0]   w_sreg_nxt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [PH_W-1:0]    w_ph_nxt;

    logic               w_seg_ack_nxt;
    logic               w_led_ack_nxt;
    logic               w_busy_nxt;
    logic               w_seg_clk_nxt;
    logic               w_seg_sout_nxt;
    logic               w_seg_pen_nxt;
    logic               w_led_clk_nxt;
    logic               w_led_sout_nxt;
    logic               w_led_pen_nxt;

    logic               w_ph_wrap;
    logic [MAX_W-1:0]   w_seg_load;
    logic [MAX_W-1:0]   w_led_load;
    logic [MAX_W-1:0]   w_sreg_shift;
    logic               w_sout_nxt;

    // Last phase of a bit period (or of the latch window)
    assign w_ph_wrap = (r_ph_cnt == PH_W'(PH_N - 1));

    // Bit-order dependent alignment, shift direction and emitted bit
`ifdef SERIAL_LSB_FIRST_EN
    assign w_seg_load   = MAX_W'(seg_data);
    assign w_led_load   = MAX_W'(led_data);
    assign w_sreg_shift = r_sreg >> 1;
    assign w_sout_nxt   = w_sreg_nxt[0];
`else
    assign w_seg_load   = MAX_W'(seg_data) << (MAX_W - SEG_W);
    assign w_led_load   = MAX_W'(led_data) << (MAX_W - LED_W);
    assign w_sreg_shift = r_sreg << 1;
    assign w_sout_nxt   = w_sreg_nxt[MAX_W-1];
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (seg_req || led_req) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // Last phase of the final bit
                if (w_ph_wrap && (r_bit_cnt <= CNT_W'(1))) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (w_ph_wrap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant, pointer, shift register and counters
    always_comb begin
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_sreg_nxt    = r_sreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ph_nxt      = r_ph_cnt;
        case (r_state)
            S_IDLE: begin
                w_ph_nxt = '0;
                // Both requesting: serve the channel not served last
                if (seg_req && led_req) begin
                    w_grant_nxt = ~r_last;
                end else if (led_req) begin
                    w_grant_nxt = G_LED;
                end else if (seg_req) begin
                    w_grant_nxt = G_SEG;
                end
            end
            S_LOAD: begin
                w_last_nxt = r_grant;
                w_ph_nxt   = '0;
                if (r_grant == G_LED) begin
                    w_sreg_nxt    = w_led_load;
                    w_bit_cnt_nxt = CNT_W'(LED_W);
                end else begin
                    w_sreg_nxt    = w_seg_load;
                    w_bit_cnt_nxt = CNT_W'(SEG_W);
                end
            end
            S_SHIFT: begin
                if (w_ph_wrap) begin
                    w_ph_nxt   = '0;
                    w_sreg_nxt = w_sreg_shift;
                    if (r_bit_cnt != '0) begin
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                    end
                end else begin
                    w_ph_nxt = r_ph_cnt + PH_W'(1);
                end
            end
            S_LATCH: begin
                if (w_ph_wrap) begin
                    w_ph_nxt = '0;
                end else begin
                    w_ph_nxt = r_ph_cnt + PH_W'(1);
                end
            end
            default: begin
                w_ph_nxt = '0;
            end
        endcase
    end

    // Output decode of the next-cycle state
    always_comb begin
        w_seg_ack_nxt  = 1'b0;
        w_led_ack_nxt  = 1'b0;
        w_seg_clk_nxt  = 1'b0;
        w_seg_sout_nxt = 1'b0;
        w_seg_pen_nxt  = 1'b0;
        w_led_clk_nxt  = 1'b0;
        w_led_sout_nxt = 1'b0;
        w_led_pen_nxt  = 1'b0;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_LOAD: begin
                if (w_grant_nxt == G_LED) begin
                    w_led_ack_nxt = 1'b1;
                end else begin
                    w_seg_ack_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                // Shift clock low for the first DIV phases, high for the last DIV
                if (w_grant_nxt == G_LED) begin
                    w_led_clk_nxt  = (w_ph_nxt >= PH_W'(DIV));
                    w_led_sout_nxt = w_sout_nxt;
                end else begin
                    w_seg_clk_nxt  = (w_ph_nxt >= PH_W'(DIV));
                    w_seg_sout_nxt = w_sout_nxt;
                end
            end
            S_LATCH: begin
                if (w_grant_nxt == G_LED) begin
                    w_led_pen_nxt = 1'b1;
                end else begin
                    w_seg_pen_nxt = 1'b1;
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath registers; pointer resets to "LED served last"
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant   <= G_SEG;
            r_last    <= G_LED;
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_ph_cnt  <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_sreg    <= w_sreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_ph_cnt  <= w_ph_nxt;
        end
    end

    // Output registers; clear lines release on the first edge after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_seg_ack  <= 1'b0;
            r_led_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_seg_clk  <= 1'b0;
            r_seg_sout <= 1'b0;
            r_seg_pen  <= 1'b0;
            r_seg_clrn <= 1'b0;
            r_led_clk  <= 1'b0;
            r_led_sout <= 1'b0;
            r_led_pen  <= 1'b0;
            r_led_clrn <= 1'b0;
        end else begin
            r_seg_ack  <= w_seg_ack_nxt;
            r_led_ack  <= w_led_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_seg_clk  <= w_seg_clk_nxt;
            r_seg_sout <= w_seg_sout_nxt;
            r_seg_pen  <= w_seg_pen_nxt;
            r_seg_clrn <= 1'b1;
            r_led_clk  <= w_led_clk_nxt;
            r_led_sout <= w_led_sout_nxt;
            r_led_pen  <= w_led_pen_nxt;
            r_led_clrn <= 1'b1;
        end
    end

    assign seg_ack  = r_seg_ack;
    assign led_ack  = r_led_ack;
    assign busy     = r_busy;
    assign seg_clk  = r_seg_clk;
    assign seg_sout = r_seg_sout;
    assign seg_pen  = r_seg_pen;
    assign seg_clrn = r_seg_clrn;
    assign led_clk  = r_led_clk;
    assign led_sout = r_led_sout;
    assign led_pen  = r_led_pen;
    assign led_clrn = r_led_clrn;

endmodule

// File: tb/tb_serial_shift_arbiter.sv
`timescale 1ns/1ps
module tb_serial_shift_arbiter;

    localparam int unsigned SEG_W = 64;
    localparam int unsigned LED_W = 16;
    localparam int unsigned DIV   = 2;
    localparam int SEG_BUSY = 1 + SEG_W * 2 * DIV + 2 * DIV;
    localparam int LED_BUSY = 1 + LED_W * 2 * DIV + 2 * DIV;
    localparam int PEN_LEN  = 2 * DIV;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             seg_req = 1'b0;
    logic [SEG_W-1:0] seg_data = '0;
    logic             seg_ack;
    logic             led_req = 1'b0;
    logic [LED_W-1:0] led_data = '0;
    logic             led_ack;
    logic             busy;
    logic             seg_clk, seg_sout, seg_pen, seg_clrn;
    logic             led_clk, led_sout, led_pen, led_clrn;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit seg_exp_q[$];
    bit led_exp_q[$];

    serial_shift_arbiter #(.SEG_W(SEG_W), .LED_W(LED_W), .DIV(DIV)) dut (
        .clk(clk), .rstn(rstn),
        .seg_req(seg_req), .seg_data(seg_data), .seg_ack(seg_ack),
        .led_req(led_req), .led_data(led_data), .led_ack(led_ack),
        .busy(busy),
        .seg_clk(seg_clk), .seg_sout(seg_sout), .seg_pen(seg_pen), .seg_clrn(seg_clrn),
        .led_clk(led_clk), .led_sout(led_sout), .led_pen(led_pen), .led_clrn(led_clrn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: each rising shift clock pops the expected bit
    logic prev_seg_clk = 1'b0, prev_led_clk = 1'b0;
    int   seg_last_rise = 0, led_last_rise = 0;
    bit   seg_rise_valid = 0, led_rise_valid = 0;
    always @(negedge clk) begin
        bit e;
        if (rstn) begin
            if (led_ack) led_rise_valid = 0;
            if (seg_ack) seg_rise_valid = 0;
            if (led_clk && !prev_led_clk) begin
                n_checks++;
                if (led_exp_q.size() == 0) begin
                    n_fail++; $display("FAIL led_unexpected_bit: got rise at cycle %0d, required none", cyc);
                end else begin
                    e = led_exp_q.pop_front();
                    if (led_sout !== e) begin
                        n_fail++; $display("FAIL led_bit: got %b required %b (%0d left)", led_sout, e, led_exp_q.size());
                    end
                end
                if (led_rise_valid) begin
                    n_checks++;
                    if (cyc - led_last_rise != 2 * DIV) begin
                        n_fail++; $display("FAIL led_rise_gap: got %0d required %0d", cyc - led_last_rise, 2 * DIV);
                    end
                end
                led_last_rise = cyc; led_rise_valid = 1;
            end
            if (seg_clk && !prev_seg_clk) begin
                n_checks++;
                if (seg_exp_q.size() == 0) begin
                    n_fail++; $display("FAIL seg_unexpected_bit: got rise at cycle %0d, required none", cyc);
                end else begin
                    e = seg_exp_q.pop_front();
                    if (seg_sout !== e) begin
                        n_fail++; $display("FAIL seg_bit: got %b required %b (%0d left)", seg_sout, e, seg_exp_q.size());
                    end
                end
                if (seg_rise_valid) begin
                    n_checks++;
                    if (cyc - seg_last_rise != 2 * DIV) begin
                        n_fail++; $display("FAIL seg_rise_gap: got %0d required %0d", cyc - seg_last_rise, 2 * DIV);
                    end
                end
                seg_last_rise = cyc; seg_rise_valid = 1;
            end
            if (led_pen) begin
                n_checks++;
                if ({led_clk, led_sout} !== 2'b00) begin
                    n_fail++; $display("FAIL led_latch_pins: got clk/sout %b%b required 00", led_clk, led_sout);
                end
            end
            if (seg_pen) begin
                n_checks++;
                if ({seg_clk, seg_sout} !== 2'b00) begin
                    n_fail++; $display("FAIL seg_latch_pins: got clk/sout %b%b required 00", seg_clk, seg_sout);
                end
            end
            if ((seg_clk | seg_sout | seg_pen) && (led_clk | led_sout | led_pen)) begin
                n_checks++; n_fail++;
                $display("FAIL both_chains_active: got seg %b%b%b led %b%b%b required one idle",
                         seg_clk, seg_sout, seg_pen, led_clk, led_sout, led_pen);
            end
        end
        prev_seg_clk = seg_clk;
        prev_led_clk = led_clk;
    end

    task automatic push_led(input logic [LED_W-1:0] d);
        for (int i = 0; i < int'(LED_W); i++) begin
`ifdef SERIAL_LSB_FIRST_EN
            led_exp_q.push_back(d[i]);
`else
            led_exp_q.push_back(d[LED_W-1-i]);
`endif
        end
    endtask

    task automatic push_seg(input logic [SEG_W-1:0] d);
        for (int i = 0; i < int'(SEG_W); i++) begin
`ifdef SERIAL_LSB_FIRST_EN
            seg_exp_q.push_back(d[i]);
`else
            seg_exp_q.push_back(d[SEG_W-1-i]);
`endif
        end
    endtask

    // Negedges until the chosen ack is seen (bounded)
    task automatic wait_ack(input bit want_led, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(want_led ? led_ack : seg_ack) && lat < 20);
    endtask

    // From the current sample, count busy cycles, latch cycles, acks and foreign-chain activity
    task automatic measure_busy(input bit is_led, output int b, output int p, output int a, output int other);
        b = 0; p = 0; a = 0; other = 0;
        while (busy && b < 2000) begin
            b++;
            if (is_led ? led_pen : seg_pen) p++;
            if (seg_ack | led_ack) a++;
            if (is_led ? (seg_clk | seg_sout | seg_pen) : (led_clk | led_sout | led_pen)) other++;
            @(negedge clk);
        end
    endtask

    // Idle samples before the next ack (bounded)
    task automatic wait_idle_then_ack(output int idle_n);
        idle_n = 0;
        while (!(seg_ack || led_ack) && idle_n < 20) begin
            idle_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit act;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seg_ack, led_ack, busy, seg_clk, seg_sout, seg_pen, seg_clrn,
             led_clk, led_sout, led_pen, led_clrn} !== 11'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b required all 0",
                {seg_ack, led_ack, busy, seg_clk, seg_sout, seg_pen, seg_clrn, led_clk, led_sout, led_pen, led_clrn});
        end
        rstn = 1'b1;
        #1;
        n_checks++;
        if ({seg_clrn, led_clrn} !== 2'b00) begin
            n_fail++; $display("FAIL clrn_before_edge: got %b required 00", {seg_clrn, led_clrn});
        end
        @(negedge clk);
        n_checks++;
        if ({seg_clrn, led_clrn} !== 2'b11) begin
            n_fail++; $display("FAIL clrn_after_edge: got %b required 11", {seg_clrn, led_clrn});
        end
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy | seg_ack | led_ack) act = 1;
        end
        n_checks++;
        if (act !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: got activity %b required 0", act);
        end
    endtask

    task automatic test_led_basic();
        int lat, b, p, a, o;
        led_data = 16'h8561;
        push_led(16'h8561);
        led_req = 1'b1;
        wait_ack(1'b1, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL led_ack_latency: got %0d required 1", lat); end
        led_req = 1'b0;
        measure_busy(1'b1, b, p, a, o);
        n_checks++;
        if (b != LED_BUSY) begin n_fail++; $display("FAIL led_busy_len: got %0d required %0d", b, LED_BUSY); end
        n_checks++;
        if (p != PEN_LEN) begin n_fail++; $display("FAIL led_pen_len: got %0d required %0d", p, PEN_LEN); end
        n_checks++;
        if (a != 1) begin n_fail++; $display("FAIL led_ack_width: got %0d required 1", a); end
        n_checks++;
        if (o != 0) begin n_fail++; $display("FAIL led_seg_pins_idle: got %0d active cycles required 0", o); end
        n_checks++;
        if (led_exp_q.size() != 0) begin n_fail++; $display("FAIL led_bits_left: got %0d required 0", led_exp_q.size()); end
    endtask

    task automatic test_arbitration();
        int lat, b, p, a, o, idle_n;
        seg_data = 64'hBD8C_8561_0000_FFFF;
        push_seg(64'hBD8C_8561_0000_FFFF);
        seg_req = 1'b1;
        wait_ack(1'b0, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL seg_ack_latency: got %0d required 1", lat); end
        seg_req = 1'b0;
        measure_busy(1'b0, b, p, a, o);
        n_checks++;
        if (b != SEG_BUSY) begin n_fail++; $display("FAIL seg_busy_len: got %0d required %0d", b, SEG_BUSY); end
        n_checks++;
        if (o != 0) begin n_fail++; $display("FAIL seg_led_pins_idle: got %0d required 0", o); end
        // Both requests raised together: LED was not served last
        led_data = 16'h8561;
        push_led(16'h8561);
        push_seg(64'hBD8C_8561_0000_FFFF);
        led_req = 1'b1;
        seg_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({led_ack, seg_ack} !== 2'b10) begin
            n_fail++; $display("FAIL rr_first_grant: got led/seg ack %b required 10", {led_ack, seg_ack});
        end
        led_req = 1'b0;
        measure_busy(1'b1, b, p, a, o);
        n_checks++;
        if (b != LED_BUSY) begin n_fail++; $display("FAIL rr_led_busy: got %0d required %0d", b, LED_BUSY); end
        wait_idle_then_ack(idle_n);
        n_checks++;
        if (idle_n != 1 || seg_ack !== 1'b1) begin
            n_fail++; $display("FAIL rr_second_grant: got idle %0d seg_ack %b required 1 and 1", idle_n, seg_ack);
        end
        seg_req = 1'b0;
        measure_busy(1'b0, b, p, a, o);
        n_checks++;
        if (b != SEG_BUSY) begin n_fail++; $display("FAIL rr_seg_busy: got %0d required %0d", b, SEG_BUSY); end
        n_checks++;
        if (p != PEN_LEN) begin n_fail++; $display("FAIL rr_seg_pen: got %0d required %0d", p, PEN_LEN); end
        n_checks++;
        if (seg_exp_q.size() + led_exp_q.size() != 0) begin
            n_fail++; $display("FAIL rr_bits_left: got %0d required 0", seg_exp_q.size() + led_exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int lat, b, p, a, o, t;
        seg_data = 64'hBD8C_8561_0000_FFFF;
        push_seg(64'hBD8C_8561_0000_FFFF);
        seg_req = 1'b1;
        wait_ack(1'b0, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL mid_ack_latency: got %0d required 1", lat); end
        t = 0;
        while (seg_exp_q.size() > int'(SEG_W) - 10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (seg_exp_q.size() != int'(SEG_W) - 10) begin
            n_fail++; $display("FAIL mid_bits_before_reset: got %0d required %0d", seg_exp_q.size(), SEG_W - 10);
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({seg_ack, led_ack, busy, seg_clk, seg_sout, seg_pen, seg_clrn,
             led_clk, led_sout, led_pen, led_clrn} !== 11'b0) begin
            n_fail++; $display("FAIL mid_async_reset: got %b required all 0",
                {seg_ack, led_ack, busy, seg_clk, seg_sout, seg_pen, seg_clrn, led_clk, led_sout, led_pen, led_clrn});
        end
        // Aborted transfer restarts from the first bit
        seg_exp_q.delete();
        push_seg(64'hBD8C_8561_0000_FFFF);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_ack(1'b0, lat);
        n_checks++;
        if (lat != 1 || seg_clrn !== 1'b1) begin
            n_fail++; $display("FAIL mid_restart_ack: got lat %0d clrn %b required 1 and 1", lat, seg_clrn);
        end
        seg_req = 1'b0;
        measure_busy(1'b0, b, p, a, o);
        n_checks++;
        if (b != SEG_BUSY) begin n_fail++; $display("FAIL mid_restart_busy: got %0d required %0d", b, SEG_BUSY); end
        n_checks++;
        if (seg_exp_q.size() != 0) begin n_fail++; $display("FAIL mid_bits_left: got %0d required 0", seg_exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int lat, b, p, a, o, idle_n;
        led_data = 16'h8561;
        for (int k = 0; k < 3; k++) push_led(16'h8561);
        led_req = 1'b1;
        wait_ack(1'b1, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL b2b_ack_latency: got %0d required 1", lat); end
        for (int k = 0; k < 3; k++) begin
            measure_busy(1'b1, b, p, a, o);
            n_checks++;
            if (b != LED_BUSY || a != 1) begin
                n_fail++; $display("FAIL b2b_busy_%0d: got busy %0d acks %0d required %0d and 1", k, b, a, LED_BUSY);
            end
            if (k < 2) begin
                wait_idle_then_ack(idle_n);
                n_checks++;
                if (idle_n != 1) begin n_fail++; $display("FAIL b2b_idle_gap_%0d: got %0d required 1", k, idle_n); end
                if (k == 1) led_req = 1'b0;
            end
        end
        wait_idle_then_ack(idle_n);
        n_checks++;
        if (idle_n != 20) begin n_fail++; $display("FAIL b2b_no_extra_ack: got ack after %0d idle required none", idle_n); end
        n_checks++;
        if (led_exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_bits_left: got %0d required 0", led_exp_q.size()); end
    endtask

    task automatic test_data_hold();
        int lat, b, p, a, o;
        led_data = 16'h8561;
        push_led(16'h8561);
        led_req = 1'b1;
        wait_ack(1'b1, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL hold_ack_latency: got %0d required 1", lat); end
        led_req = 1'b0;
        @(posedge clk);
        #1;
        led_data = 16'h0000;
        @(negedge clk);
        measure_busy(1'b1, b, p, a, o);
        n_checks++;
        if (b != LED_BUSY - 1) begin n_fail++; $display("FAIL hold_busy: got %0d required %0d", b, LED_BUSY - 1); end
        n_checks++;
        if (led_exp_q.size() != 0) begin n_fail++; $display("FAIL hold_bits_left: got %0d required 0", led_exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_led_basic();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        test_data_hold();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
